// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin bus arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 8;

  // Width of an index able to name any of n requesters.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from i_ptr, wrapping from the top index back to 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int SEL_W = sel_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_found,
  output logic [SEL_W-1:0] o_idx,
  output logic [N_REQ-1:0] o_onehot
);

  logic [SEL_W-1:0] w_scan;

  // Scan from the far end down so the candidate closest to i_ptr is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_scan  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_scan = SEL_W'((int'(i_ptr) + k) % N_REQ);
      if (i_req[w_scan]) begin
        o_found = 1'b1;
        o_idx   = w_scan;
      end
    end
    o_onehot = N_REQ'(o_found) << o_idx;
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Demand-driven round-robin arbiter for a shared data bus with burst limiting.
// Build with ARB_PRIORITY_EN defined to make requester 0 high-priority.
module rr_bus_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4,
  localparam int SEL_W = sel_w(N_REQ),
  localparam int CNT_W = $clog2(MAX_BURST + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  output logic [N_REQ-1:0]        grant,
  output logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       data_out,
  output logic                    data_valid,
  output logic                    busy
);

  arb_state_t        r_state, w_state_nxt;
  logic [N_REQ-1:0]  r_grant, w_grant_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0]  r_ptr, w_ptr_nxt;
  logic [DATA_W-1:0] r_dout;
  logic              r_dv;

  logic              w_cont, w_accept, w_prio, w_found, w_win_found;
  logic [SEL_W-1:0]  w_ptr_adv, w_pick_ptr, w_idx, w_win_idx;
  logic [N_REQ-1:0]  w_pick_oh, w_win_oh;
  logic [DATA_W-1:0] w_word;

  assign w_accept  = |(r_grant & req);
  assign w_word    = data_in[int'(r_sel)*DATA_W +: DATA_W];
  assign w_cont    = (r_state == GRANT) && req[r_sel] && (r_cnt < CNT_W'(MAX_BURST));
  assign w_ptr_adv = (r_sel == SEL_W'(N_REQ - 1)) ? '0 : r_sel + SEL_W'(1);
  // Releasing owner g scans from g+1, so g itself is only re-picked if alone.
  assign w_pick_ptr = (r_state == IDLE) ? r_ptr : w_ptr_adv;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req    (req),
    .i_ptr    (w_pick_ptr),
    .o_found  (w_found),
    .o_idx    (w_idx),
    .o_onehot (w_pick_oh)
  );

`ifdef ARB_PRIORITY_EN
  // Requester 0 wins every decision except the one that ends its own burst.
  assign w_prio = req[0] && !((r_state == GRANT) && (r_sel == '0));
`else
  assign w_prio = 1'b0;
`endif

  assign w_win_found = w_found | w_prio;
  assign w_win_idx   = w_prio ? '0 : w_idx;
  assign w_win_oh    = w_prio ? N_REQ'(1) : w_pick_oh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_dout  <= '0;
      r_dv    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_dv    <= w_accept;
      if (w_accept) r_dout <= w_word;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_win_found) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_win_oh;
          w_sel_nxt   = w_win_idx;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (w_cont) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_ptr_nxt = w_ptr_adv;
          if (w_win_found) begin
            w_grant_nxt = w_win_oh;
            w_sel_nxt   = w_win_idx;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == GRANT);
  end

  assign grant      = r_grant;
  assign sel        = r_sel;
  assign data_out   = r_dout;
  assign data_valid = r_dv;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Randomized and directed bench for rr_bus_arbiter against a behavioural model.
module tb_rr_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
`ifdef ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]  grant;
  logic [1:0]    sel;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          busy;

  always #5 clk = ~clk;

  rr_bus_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data_in    (data_in),
    .grant      (grant),
    .sel        (sel),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus, how long, and where the scan starts next.
  int       m_owner;
  int       m_cnt;
  int       m_ptr;
  int       m_sel;
  logic [DW-1:0] m_dout;
  logic     m_dv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int choose(input logic [N-1:0] r, input int ptr, input bit allow_prio);
    if (PRIO && allow_prio && r[0]) return 0;
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rst_v, input logic [N-1:0] r, input logic [N*DW-1:0] d);
    if (rst_v) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_sel = 0; m_dout = '0; m_dv = 1'b0;
      return;
    end
    m_dv = (m_owner >= 0) && r[m_owner];
    if (m_dv) m_dout = d[m_owner*DW +: DW];
    if (m_owner < 0) begin
      m_owner = choose(r, m_ptr, 1'b1);
      m_cnt   = (m_owner >= 0) ? 1 : 0;
    end else if (r[m_owner] && m_cnt < MB) begin
      m_cnt++;
    end else begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = choose(r, m_ptr, m_owner != 0);
      m_cnt   = (m_owner >= 0) ? 1 : 0;
    end
    if (m_owner >= 0) m_sel = m_owner;
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic rst_v, input logic [N-1:0] r, input logic [N*DW-1:0] d);
    rst = rst_v; req = r; data_in = d;
    model_step(rst_v, r, d);
    @(posedge clk);
    #1;
    check("grant", 32'(grant), (m_owner >= 0) ? 32'(1) << m_owner : 32'd0);
    check("sel", 32'(sel), 32'(m_sel));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("data_valid", 32'(data_valid), 32'(m_dv));
    check("data_out", 32'(data_out), 32'(m_dout));
    check("onehot0", 32'($onehot0(grant)), 32'd1);
  endtask

  logic [N-1:0] r_cur;

  initial begin
    rst = 1'b1; req = '0; data_in = '0;
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_sel = 0; m_dout = '0; m_dv = 1'b0;
    @(posedge clk); #1;
    step(1'b1, '0, '0);
    check("reset_grant", 32'(grant), 32'd0);

    // Full contention: bursts of MB per requester in index order.
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 4'b1111, 32'($urandom));
`ifndef ARB_PRIORITY_EN
      check("rotation", 32'(sel), 32'((i / MB) % N));
`endif
    end

    // Reset asserted mid-burst wins over everything.
    step(1'b1, 4'b1111, '0);
    step(1'b1, 4'b1111, '0);
    check("rst_mid_grant", 32'(grant), 32'd0);
    check("rst_mid_dv", 32'(data_valid), 32'd0);
    step(1'b0, 4'b1111, '0);
    check("rst_first_win", 32'(grant), 32'b0001);

    step(1'b0, 4'b0000, '0);
    step(1'b0, 4'b0000, '0);

    // Lone requester 2: grant after one edge, then seamless re-grant at the burst limit.
    step(1'b0, 4'b0100, 32'h00A5_0000);
    check("single_grant", 32'(grant), 32'b0100);
    check("single_sel", 32'(sel), 32'd2);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'b0100, 32'h00A5_0000);
      check("single_dout", 32'(data_out), 32'hA5);
      check("single_grant_hold", 32'(grant), 32'b0100);
    end

    // Pointer now sits past requester 2; 3 should beat 0 in the default build.
    step(1'b0, 4'b1001, 32'h1122_3344);
`ifndef ARB_PRIORITY_EN
    check("wrap_win3", 32'(grant), 32'b1000);
`else
    check("prio_win0", 32'(grant), 32'b0001);
`endif
    for (int i = 0; i < 6; i++) step(1'b0, 4'b1001, 32'($urandom));

    step(1'b0, 4'b0000, '0);
    step(1'b0, 4'b0000, '0);

    // Early drop: requester 1 lets go, requester 3 takes over without capture.
    step(1'b0, 4'b0010, 32'h0000_5A00);
    step(1'b0, 4'b0010, 32'h0000_5A00);
    step(1'b0, 4'b0010, 32'h0000_5A00);
    step(1'b0, 4'b1000, 32'h7700_0000);
    check("drop_grant", 32'(grant), 32'b1000);
    check("drop_dv", 32'(data_valid), 32'd0);
    check("drop_dout", 32'(data_out), 32'h5A);

    // Randomized traffic with sticky requests and occasional resets.
    r_cur = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3) r_cur = 4'($urandom_range(0, 15));
      step($urandom_range(0, 59) == 0, r_cur, 32'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter sharing one DATA_W-bit data bus between N_REQ senders.
- Grants one requester at a time and drives the select index (`sel`), in the same sense as the Sel line on the monitor interface.
- Captures the granted sender's data into a registered output with a valid flag.
- Sits between the sender blocks and the receiver side of the monitor bus; it replaces the free-running Sel counter with demand-driven sequencing.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, data bus width
- MAX_BURST, 4, maximum consecutive grant cycles per requester before forced rotation (1..15)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req  in  N_REQ  per-requester request, level-sensitive
- data_in  in  N_REQ*DATA_W  packed sender data; requester i occupies bits [i*DATA_W +: DATA_W]
- grant  out  N_REQ  one-hot grant, registered
- sel  out  $clog2(N_REQ)  index of granted requester, registered
- data_out  out  DATA_W  captured data of granted requester, registered
- data_valid  out  1  data_out holds a word accepted in the previous cycle
- busy  out  1  high while in GRANT state

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - Reset is synchronous and active-high on `rst`; it overrides all other activity, including mid-burst.
- Reset values:
  - grant=0, sel=0, data_out=0, data_valid=0, busy=0.
  - state=IDLE, rr_ptr=0, burst_cnt=0.
- States:
  - IDLE: no grant. If any req bit is high, pick the winner, set grant/sel to it, burst_cnt=1, and go to GRANT. Otherwise stay.
  - GRANT: requester g is granted.
    - Continue condition: req[g]=1 and burst_cnt<MAX_BURST. Hold the grant and increment burst_cnt.
    - Release condition: req[g]=0 or burst_cnt==MAX_BURST. Set rr_ptr=(g+1) mod N_REQ.
    - On release, if any other req bit is high: re-arbitrate in the same cycle, grant the new winner, burst_cnt=1, stay in GRANT. No idle bubble.
    - On release with no other requester, but req[g] still high (burst limit case): re-grant g, since round-robin from the advanced pointer finds only g.
    - On release with no requests at all: clear grant and go to IDLE.
- Winner selection: first set req bit scanning upward from rr_ptr, wrapping N_REQ-1 to 0.
- Latency:
  - req rising at edge t gives grant at edge t+1.
  - A word is accepted in any cycle where grant[g]=1 and req[g]=1. data_out=data_in[g] and data_valid=1 are registered at the next edge.
  - data_valid=0 in cycles following non-accept cycles.
- sel always equals the encoded grant; it holds its last value while grant=0.
- Invariants:
  - grant is never multi-hot.
  - A requester dropping req while granted loses the grant at the next edge; no word is captured for that cycle.
- burst_cnt width: $clog2(MAX_BURST+1); it never wraps.

Optional Feature:
- Macro: ARB_PRIORITY_EN
- Defined: requester 0 is high-priority. At every arbitration decision (IDLE pick or release), req[0]=1 wins regardless of rr_ptr. rr_ptr still advances only on release. Requester 0 remains subject to MAX_BURST: after its limit, if others request, one other requester is granted before 0 can win again.
- Undefined: pure round-robin as above.

Decomposition:
- Package arb_pkg:
  - state enum `arb_state_t` {IDLE, GRANT}
  - localparam function for select width
  - shared default constants DATA_W_DEF=8, N_REQ_DEF=4
- Sub-module rr_pick, combinational:
  - Inputs: req, ptr.
  - Outputs: found, winner index, one-hot.
  - Instantiated once in rr_bus_arbiter.

Test Plan:
- Reset: assert rst 2 cycles mid-burst with req=4'b1111 -> next cycle grant=0, data_valid=0, sel=0, busy=0; first grant after release is requester 0.
- Single requester: req=4'b0100, data_in[2]=8'hA5 -> grant=4'b0100 and sel=2 one cycle later; then data_out=8'hA5, data_valid=1 each accept; after 4 cycles a forced release re-grants 2 with no gap.
- Rotation: req=4'b1111 held, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,2,...,3,3,3,3,0; never multi-hot.
- Early drop: requester 1 granted, drops req after 2 cycles, req[3]=1 -> grant moves to 3 the next edge; data_valid=0 for the dropped cycle.
- Wrap: rr_ptr=3, req=4'b1001 -> 3 wins; after release 0 wins.
- ARB_PRIORITY_EN: req=4'b0011 with rr_ptr=1 -> 0 wins; after its 4-cycle burst, 1 gets 4 cycles, then 0 again.
